// File: rtl/frame_compositor.sv
// frame_compositor: scaled frame-buffer pixel lookup with overlay priority compositing.
// Define FRAME_COMPOSITOR_CLEAR_EN to build in the hardware frame-clear FSM.
module frame_compositor #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int BPP = 4,
    parameter int SCALE = 2,
    parameter int WORD_W = 16,
    parameter int N_OVL = 2,
    parameter logic [BPP-1:0] TRANSP = {BPP{1'b1}},
    localparam int PPW = WORD_W / BPP,
    localparam int DEPTH = (H_RES / SCALE) * (V_RES / SCALE) / PPW,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [9:0]           DrawX,
    input  logic [9:0]           DrawY,
    input  logic                 pix_req,
    input  logic [N_OVL*BPP-1:0] ovl_color,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WORD_W-1:0]    wr_data,
    input  logic                 clear_req,
    output logic                 clear_busy,
    output logic [BPP-1:0]       color_enum,
    output logic                 color_valid
);
    localparam int LW = PPW > 1 ? $clog2(PPW) : 1;

    logic [31:0] p;
    logic oob;
    logic [AW-1:0] rd_addr;
    logic [LW-1:0] lane;
    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rd_data;
    logic we;
    logic [AW-1:0] wa;
    logic [WORD_W-1:0] wd;
    logic s1_valid, s1_oob;
    logic [LW-1:0] s1_lane;
    logic [N_OVL*BPP-1:0] s1_ovl;
    logic [BPP-1:0] frame_pix, pix;

    // S0: pixel index kept 32 bits wide so nothing truncates before the division
    always_comb begin
        p = 32'(DrawY) / 32'(SCALE) * 32'(H_RES / SCALE) + 32'(DrawX) / 32'(SCALE);
        oob = 32'(DrawX) >= 32'(H_RES) || 32'(DrawY) >= 32'(V_RES);
        rd_addr = oob ? '0 : AW'(p / 32'(PPW));
        lane = LW'(p % 32'(PPW));
    end

`ifdef FRAME_COMPOSITOR_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state, state_nxt;
    logic [AW-1:0] cnt;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt <= state == CLEAR ? cnt + 1'b1 : '0;
        end
    end

    always_comb
        state_nxt = state == IDLE ? (clear_req ? CLEAR : IDLE)
                                  : (cnt == AW'(DEPTH - 1) ? IDLE : CLEAR);

    always_comb begin
        clear_busy = state == CLEAR;
        wr_ready = !clear_busy;
    end
`else
    logic [AW-1:0] cnt;
    logic unused_clear;
    assign cnt = '0;
    assign unused_clear = clear_req;
    assign clear_busy = 1'b0;
    assign wr_ready = 1'b1;
`endif

    always_comb begin
        we = clear_busy || (wr_valid && wr_ready);
        wa = clear_busy ? cnt : wr_addr;
        wd = clear_busy ? '0 : wr_data;
    end

    // Read-before-write RAM: a same-cycle write/read to one word returns the old word
    always_ff @(posedge Clk) begin
        if (we) mem[wa] <= wd;
        rd_data <= mem[rd_addr];
    end

    // Lowest-index opaque overlay wins, so scan from the top down and let lower indices overwrite
    always_comb begin
        frame_pix = BPP'(rd_data >> (BPP * (PPW - 1 - int'(s1_lane))));
        pix = frame_pix;
        for (int i = N_OVL - 1; i >= 0; i--)
            if (s1_ovl[i*BPP +: BPP] != TRANSP) pix = s1_ovl[i*BPP +: BPP];
        if (s1_oob) pix = '0;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            s1_valid <= 1'b0;
            s1_oob <= 1'b0;
            s1_lane <= '0;
            s1_ovl <= '0;
            color_valid <= 1'b0;
            color_enum <= '0;
        end else begin
            s1_valid <= pix_req;
            s1_oob <= oob;
            s1_lane <= lane;
            s1_ovl <= ovl_color;
            color_valid <= s1_valid;
            if (s1_valid) color_enum <= pix;
        end
    end
endmodule

// File: tb/tb_frame_compositor.sv
// tb_frame_compositor: randomized and directed checks against a shadow-frame reference model.
module tb_frame_compositor;
    localparam int DEPTH = 19200;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic [9:0] DrawX = '0, DrawY = '0;
    logic pix_req = 1'b0;
    logic [7:0] ovl_color = 8'hff;
    logic wr_valid = 1'b0;
    logic wr_ready;
    logic [14:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic clear_req = 1'b0;
    logic clear_busy;
    logic [3:0] color_enum;
    logic color_valid;

    int n_tests = 0, n_fail = 0;
    logic [15:0] shadow [DEPTH];
    bit qv[$];
    logic [3:0] qc[$];
    logic [3:0] last = '0;
    bit in_clear = 1'b0;

    frame_compositor dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .pix_req(pix_req),
        .ovl_color(ovl_color), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .clear_req(clear_req), .clear_busy(clear_busy),
        .color_enum(color_enum), .color_valid(color_valid)
    );

    always #5 Clk = ~Clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] model(input int x, input int y, input logic [7:0] ovl);
        int p;
        if (x >= 640 || y >= 480) return 4'h0;
        if (ovl[3:0] != 4'hf) return ovl[3:0];
        if (ovl[7:4] != 4'hf) return ovl[7:4];
        p = (y / 2) * 320 + x / 2;
        return 4'((shadow[p / 4] >> (12 - 4 * (p % 4))) & 16'hf);
    endfunction

    task automatic step(input bit req, input int x, input int y, input logic [7:0] ovl,
                        input bit wv, input int wa, input logic [15:0] wd);
        bit v;
        logic [3:0] c;
        @(posedge Clk);
        #1;
        if (qv.size() == 2) begin
            v = qv.pop_front();
            c = qc.pop_front();
            if (v) last = c;
            check("color_valid", 32'(color_valid), 32'(v));
            check("color_enum", 32'(color_enum), 32'(last));
        end
        pix_req = req;
        DrawX = 10'(x);
        DrawY = 10'(y);
        ovl_color = ovl;
        wr_valid = wv;
        wr_addr = 15'(wa);
        wr_data = wd;
        qv.push_back(req);
        qc.push_back(model(x, y, ovl));
        if (wv && !in_clear) shadow[wa] = wd;
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 8'hff, 1'b0, 0, 16'h0);
    endtask

    task automatic rd(input int x, input int y, input logic [7:0] ovl);
        step(1'b1, x, y, ovl, 1'b0, 0, 16'h0);
    endtask

    task automatic do_reset();
        pix_req = 1'b0;
        wr_valid = 1'b0;
        clear_req = 1'b0;
        Reset = 1'b0;
        #1;
        check("rst_color_valid", 32'(color_valid), 32'd0);
        check("rst_color_enum", 32'(color_enum), 32'd0);
        check("rst_clear_busy", 32'(clear_busy), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b1;
        qv.delete();
        qc.delete();
        last = '0;
    endtask

    initial begin
        #1;
        Reset = 1'b0;
        #1;
        check("por_color_valid", 32'(color_valid), 32'd0);
        check("por_color_enum", 32'(color_enum), 32'd0);
        check("por_clear_busy", 32'(clear_busy), 32'd0);
        check("por_wr_ready", 32'(wr_ready), 32'd1);
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b1;

        for (int a = 0; a < DEPTH; a++)
            step(1'b0, 0, 0, 8'hff, 1'b1, a,
                 a == 0 ? 16'h1234 : a == 5 ? 16'hAAAA : 16'($urandom));

        rd(0, 0, 8'hff); rd(2, 0, 8'hff); rd(4, 0, 8'hff); rd(6, 0, 8'hff);
        rd(1, 1, 8'hff); rd(0, 1, 8'hff); rd(0, 2, 8'hff);
        rd(0, 0, 8'h5f); rd(0, 0, 8'h53); rd(0, 0, 8'hff);
        rd(640, 10, 8'hff); rd(639, 479, 8'hff); rd(10, 480, 8'h35); idle(); idle();
        rd(639, 479, 8'hff);
        step(1'b1, 40, 0, 8'hff, 1'b1, 5, 16'h5555);
        rd(40, 0, 8'hff);
        do_reset();

        for (int i = 0; i < 3000; i++)
            step(($urandom % 4) != 0, int'($urandom % 700), int'($urandom % 520),
                 {($urandom % 2) ? 4'hf : 4'($urandom), ($urandom % 2) ? 4'hf : 4'($urandom)},
                 ($urandom % 4) == 0, int'($urandom % DEPTH), 16'($urandom));
        idle(); idle();

`ifdef FRAME_COMPOSITOR_CLEAR_EN
        idle();
        clear_req = 1'b1;
        for (int w = 0; w < DEPTH; w++) shadow[w] = '0;
        for (int i = 0; i < DEPTH + 10; i++) begin
            in_clear = i < DEPTH;
            step(1'b0, 0, 0, 8'hff, 1'b1, i % DEPTH, 16'hBEEF);
            clear_req = i == 50;
            check("clear_busy", 32'(clear_busy), 32'(i < DEPTH));
            check("clear_wr_ready", 32'(wr_ready), 32'(i >= DEPTH));
        end
        in_clear = 1'b0;
        for (int i = 0; i < 300; i++) rd(int'($urandom % 640), int'($urandom % 480), 8'hff);
        for (int w = 0; w < 200; w++) step(1'b0, 0, 0, 8'hff, 1'b1, w, 16'hC3C3 ^ 16'(w));
        idle(); idle();
        clear_req = 1'b1;
        in_clear = 1'b1;
        for (int j = 1; j <= 101; j++) begin
            idle();
            clear_req = 1'b0;
        end
        do_reset();
        in_clear = 1'b0;
        for (int w = 0; w < 100; w++) shadow[w] = '0;
        for (int w = 95; w <= 105; w++) rd(2 * ((4 * w) % 320), 2 * ((4 * w) / 320), 8'hff);
        idle(); idle();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_compositor.md
FRAME_COMPOSITOR -- requirements
Module: frame_compositor

Interface
REQ-001 The block SHALL have these parameters: H_RES 640, screen width in pixels; V_RES 480, screen height in pixels; BPP 4, bits per color enum; SCALE 2, screen pixels per frame-buffer pixel on each axis; WORD_W 16, frame RAM word width; N_OVL 2, overlay channels; TRANSP all-ones BPP value, transparent overlay code.
REQ-002 The block SHALL derive these values: PPW = WORD_W/BPP; DEPTH = (H_RES/SCALE)*(V_RES/SCALE)/PPW; AW = clog2(DEPTH).
REQ-003 The block SHALL have these ports:
Clk  in  1  sole clock
Reset  in  1  asynchronous, active-low reset
DrawX  in  10  screen column
DrawY  in  10  screen row
pix_req  in  1  pixel lookup request
ovl_color  in  N_OVL*BPP  overlay colors; channel i at bits [i*BPP +: BPP]
wr_valid  in  1  frame write request
wr_ready  out  1  write accepted when high
wr_addr  in  AW  frame word address
wr_data  in  WORD_W  frame word data
clear_req  in  1  start hardware frame clear
clear_busy  out  1  clear in progress
color_enum  out  BPP  composited pixel color
color_valid  out  1  color_enum valid

Function
REQ-004 The block SHALL contain an internal DEPTH x WORD_W frame RAM with one synchronous write port and one synchronous read port.
REQ-005 The read path SHALL be a 3-stage pipeline (S0 address/capture, S1 RAM read, S2 output register); color_valid SHALL be asserted exactly 2 cycles after pix_req.
REQ-006 The read path SHALL accept one request per cycle with no back-pressure and no bubbles.
REQ-007 The linear frame pixel index SHALL be p = (DrawY/SCALE)*(H_RES/SCALE) + DrawX/SCALE.
REQ-008 The read word address SHALL be p/PPW, and the lane SHALL be k = p%PPW.
REQ-009 Lane k SHALL occupy bits [WORD_W-1-k*BPP -: BPP].
REQ-010 All address arithmetic SHALL be done at a width of at least AW+1 bits, with no truncation before the division.
REQ-011 The S0 stage SHALL register ovl_color and carry it alongside the RAM read so that it stays aligned with the frame pixel.
REQ-012 Composition SHALL select the lowest-index overlay channel whose value is not TRANSP; if every channel equals TRANSP, the frame pixel SHALL be output.
REQ-013 If DrawX >= H_RES or DrawY >= V_RES, color_enum SHALL be 0 and color_valid SHALL still follow pix_req.
REQ-014 When color_valid is low, color_enum SHALL hold its previous value.
REQ-015 wr_ready SHALL be high whenever clear_busy is low.
REQ-016 A write SHALL occur on the cycle where wr_valid && wr_ready is high, with a single-cycle commit.
REQ-017 A write and a read to the same word in the same cycle SHALL return the old data; the new data SHALL be visible to reads issued on the following cycle.

Reset
REQ-018 When Reset is low, color_enum SHALL be 0, color_valid SHALL be 0, all pipeline valid bits SHALL be 0, clear_busy SHALL be 0, the clear FSM SHALL be IDLE and the clear counter SHALL be 0, asynchronously.
REQ-019 Frame RAM contents SHALL NOT be affected by reset.
REQ-020 Reset asserted mid-clear SHALL abort the clear; already-cleared words SHALL stay zero and the remaining words SHALL be untouched.

Configuration
REQ-021 Macro FRAME_COMPOSITOR_CLEAR_EN SHALL, when defined, compile in a clear FSM with states IDLE and CLEAR.
REQ-022 IDLE SHALL go to CLEAR on clear_req, with the counter set to 0.
REQ-023 In CLEAR, the FSM SHALL write word 0 to address counter on each cycle and increment the counter.
REQ-024 After writing address DEPTH-1, the FSM SHALL return to IDLE.
REQ-025 clear_busy SHALL be high exactly while the FSM is in CLEAR.
REQ-026 A clear SHALL take DEPTH cycles.
REQ-027 clear_req SHALL be ignored while the FSM is in CLEAR.
REQ-028 External writes SHALL be blocked during a clear, with wr_ready low.
REQ-029 Reads SHALL continue during a clear.
REQ-030 When FRAME_COMPOSITOR_CLEAR_EN is undefined, clear_req SHALL be ignored, clear_busy SHALL be tied 0 and wr_ready SHALL be tied 1.

Verification
REQ-031 Default parameters: write addr 0 = 16'h1234, then pix_req at (0,0), (2,0), (4,0) and (6,0) with ovl all TRANSP -> color_enum 1, 2, 3, 4 on consecutive cycles, each 2 cycles after its request.
REQ-032 Scaling: pixels (1,1) and (0,1) -> same value as (0,0); pixel (0,2) -> lane 0 of word 80.
REQ-033 Priority: ovl ch0=4'hf, ch1=4'h5 -> 5; ch0=4'h3, ch1=4'h5 -> 3; both 4'hf -> frame pixel.
REQ-034 Boundary: DrawX=640, DrawY=10 -> color_enum 0 with color_valid 1; pixel (639,479) -> lane 3 of word DEPTH-1.
REQ-035 Same-cycle write/read to word 5, old 16'hAAAA, new 16'h5555 -> old lane value returned; next read returns the new value.
REQ-036 With FRAME_COMPOSITOR_CLEAR_EN: clear_req on a full frame -> clear_busy high for DEPTH=19200 cycles, wr_ready low, all reads afterwards return 0; a repeat clear_req mid-clear is ignored; Reset at cycle 100 -> words 0-99 zero, word 100 unchanged.
